// File: rtl/count_snapshot_fifo.sv
// count_snapshot_fifo
//   Records snapshots of a free-running event counter into a small
//   first-word-fall-through FIFO and drains them over valid/ready.
//   Each entry is {wrap, count}. The wrap bit is set when the counter rolled
//   over from all-ones to zero at any point since the previous accepted
//   capture.
//
//   Optional feature: define COUNT_SNAPSHOT_DROP_CNT_EN to get a saturating
//   counter of captures lost because the FIFO was full. When the macro is
//   undefined, drop_cnt is tied to zero.
//
// Ports
//   clk        system clock, rising-edge active
//   rst        asynchronous active-high reset
//   count_i    counter value, sampled every cycle
//   capture    snapshot count_i this cycle
//   out_valid  head entry valid (FIFO not empty)
//   out_ready  reader accepts the head entry this cycle
//   out_count  head entry counter value
//   out_wrap   head entry wrap flag
//   full       FIFO holds DEPTH entries
//   empty      FIFO holds no entries
//   level      number of stored entries, 0..DEPTH
//   drop_cnt   captures dropped while full (saturating at 8'hFF)

module count_snapshot_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         count_i,
    input  logic                     capture,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_count,
    output logic                     out_wrap,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] prev_count;
    logic             wrap_pending;
    logic             wrap_now;
    logic             wrap_seen;
    logic             push_ok;
    logic             pop;

    logic [AW-1:0]    head_q;
    logic [AW-1:0]    tail_q;
    logic [AW:0]      level_q;

    logic [WIDTH-1:0] mem_count [DEPTH];
    logic             mem_wrap  [DEPTH];

    assign full      = (level_q == LVL_FULL);
    assign empty     = (level_q == '0);
    assign out_valid = !empty;
    assign level     = level_q;

    // Fall-through read straight from storage; no path from capture/count_i.
    assign out_count = mem_count[head_q];
    assign out_wrap  = mem_wrap[head_q];

    always_comb begin
        wrap_now  = (prev_count == '1) && (count_i == '0);
        wrap_seen = wrap_pending | wrap_now;
        pop       = out_valid && out_ready;
        // A full FIFO still accepts a capture when the head leaves this cycle.
        push_ok   = capture && (!full || pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_count   <= '0;
            wrap_pending <= 1'b0;
            head_q       <= '0;
            tail_q       <= '0;
            level_q      <= '0;
            // Storage is cleared so out_count/out_wrap read zero after reset.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_count[i] <= '0;
                mem_wrap[i]  <= 1'b0;
            end
        end else begin
            prev_count <= count_i;

            if (push_ok) begin
                mem_count[tail_q] <= count_i;
                mem_wrap[tail_q]  <= wrap_seen;
                tail_q            <= tail_q + 1'b1;
                wrap_pending      <= 1'b0;
            end else begin
                // A dropped capture keeps the wrap for the next accepted one.
                wrap_pending <= wrap_seen;
            end

            if (pop) begin
                head_q <= head_q + 1'b1;
            end

            case ({push_ok, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

`ifdef COUNT_SNAPSHOT_DROP_CNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else if (capture && !push_ok && (drop_q != '1)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

endmodule
